// File: rtl/pipeline_latch_chain.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_latch_chain
//  Description : Chain of STAGES pipeline latches with per-stage stall and
//                flush. Stalls propagate upstream combinationally; a bubble
//                (valid 0, data 0) is inserted below the lowest held stage.
//                Saturating counters track bubble cycles and flush cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_latch_chain #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  output logic [STAGES*WIDTH-1:0]   stage_data,
  output logic [STAGES-1:0]         stage_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [CNT_W-1:0]          bubble_count,
  output logic [CNT_W-1:0]          flush_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]  r_data [STAGES];
  logic [STAGES-1:0] r_valid;
  logic [CNT_W-1:0]  r_bubble_count;
  logic [CNT_W-1:0]  r_flush_count;

  logic [STAGES-1:0] w_hold;
  logic [STAGES-1:0] w_bubble;
  logic [WIDTH-1:0]  w_src_data [STAGES];
  logic [STAGES-1:0] w_src_valid;
  logic [WIDTH-1:0]  w_next_data [STAGES];
  logic [STAGES-1:0] w_next_valid;

  // Hold chain: a stall at stage k freezes every stage upstream of it.
  assign w_hold[STAGES-1] = stall[STAGES-1];

  generate
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_hold
      assign w_hold[k] = stall[k] | w_hold[k+1];
    end
  endgenerate

  // Stage 0 is fed from the input port, later stages from their predecessor.
  // A bubble appears where a held stage feeds a stage that is free to move.
  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_src
      if (k == 0) begin : g_first
        assign w_src_data[k]  = in_data;
        assign w_src_valid[k] = in_valid;
        assign w_bubble[k]    = 1'b0;
      end else begin : g_rest
        assign w_src_data[k]  = r_data[k-1];
        assign w_src_valid[k] = r_valid[k-1];
        assign w_bubble[k]    = w_hold[k-1] & ~w_hold[k] & ~flush[k];
      end
    end
  endgenerate

  // Per-stage next state: flush beats hold, hold beats bubble, bubble beats advance.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_next_data[k]  = w_src_data[k];
      w_next_valid[k] = w_src_valid[k];
      if (flush[k]) begin
        w_next_data[k]  = '0;
        w_next_valid[k] = 1'b0;
      end else if (w_hold[k]) begin
        w_next_data[k]  = r_data[k];
        w_next_valid[k] = r_valid[k];
      end else if (w_bubble[k]) begin
        w_next_data[k]  = '0;
        w_next_valid[k] = 1'b0;
      end
    end
  end

  // Stage registers; reset empties the whole chain in a single cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_data[k] <= '0;
      end
      r_valid <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        r_data[k] <= w_next_data[k];
      end
      r_valid <= w_next_valid;
    end
  end

  // Saturating statistics: one count per cycle, however many stages are involved.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_count <= '0;
      r_flush_count  <= '0;
    end else begin
      if ((|w_bubble) && (r_bubble_count != c_cnt_max)) begin
        r_bubble_count <= r_bubble_count + c_cnt_one;
      end
      if ((|flush) && (r_flush_count != c_cnt_max)) begin
        r_flush_count <= r_flush_count + c_cnt_one;
      end
    end
  end

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_out
      assign stage_data[k*WIDTH +: WIDTH] = r_data[k];
    end
  endgenerate

  assign in_ready     = ~w_hold[0];
  assign stage_valid  = r_valid;
  assign out_data     = r_data[STAGES-1];
  assign out_valid    = r_valid[STAGES-1];
  assign bubble_count = r_bubble_count;
  assign flush_count  = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_latch_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_latch_chain
//  Description : Directed table-driven bench for pipeline_latch_chain with
//                STAGES=4, WIDTH=16, CNT_W=4, plus a counter saturation run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_latch_chain;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
  localparam int CNT_W  = 4;
  localparam int NVEC   = 23;

  logic                    clk;
  logic                    reset;
  logic [WIDTH-1:0]        in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [STAGES-1:0]       stall;
  logic [STAGES-1:0]       flush;
  logic [STAGES*WIDTH-1:0] stage_data;
  logic [STAGES-1:0]       stage_valid;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic [CNT_W-1:0]        bubble_count;
  logic [CNT_W-1:0]        flush_count;

  pipeline_latch_chain #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .stall        (stall),
    .flush        (flush),
    .stage_data   (stage_data),
    .stage_valid  (stage_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .bubble_count (bubble_count),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [15:0] din;
    logic        vin;
    logic [3:0]  stl;
    logic [3:0]  fls;
    logic        exp_ready;
    logic [3:0]  exp_sv;
    logic [63:0] exp_sd;  // {stage3, stage2, stage1, stage0}
    logic [3:0]  exp_bc;
    logic [3:0]  exp_fc;
  } vec_t;

  vec_t vecs [NVEC];
  int   tests;
  int   failed;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [15:0] d, input logic v,
                       input logic [3:0] s, input logic [3:0] f);
    reset    = r;
    in_data  = d;
    in_valid = v;
    stall    = s;
    flush    = f;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    drive(1'b1, 16'h0, 1'b0, 4'b0, 4'b0);

    //            rst din      vin stall    flush    rdy  sv       stage data {s3,s2,s1,s0}       bc     fc
    vecs[0]  = '{1'b1, 16'h0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 64'h0000_0000_0000_0000, 4'd0, 4'd0};
    vecs[1]  = '{1'b0, 16'h0001, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0001, 64'h0000_0000_0000_0001, 4'd0, 4'd0};
    vecs[2]  = '{1'b0, 16'h0002, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0011, 64'h0000_0000_0001_0002, 4'd0, 4'd0};
    vecs[3]  = '{1'b0, 16'h0003, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0111, 64'h0000_0001_0002_0003, 4'd0, 4'd0};
    vecs[4]  = '{1'b0, 16'h0004, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b1111, 64'h0001_0002_0003_0004, 4'd0, 4'd0};
    vecs[5]  = '{1'b0, 16'h0005, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b1111, 64'h0002_0003_0004_0005, 4'd0, 4'd0};
    vecs[6]  = '{1'b0, 16'h0006, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b1111, 64'h0003_0004_0005_0006, 4'd0, 4'd0};
    // stall stage 1 for two cycles with a full pipe
    vecs[7]  = '{1'b0, 16'h0007, 1'b1, 4'b0010, 4'b0000, 1'b0, 4'b1011, 64'h0004_0000_0005_0006, 4'd1, 4'd0};
    vecs[8]  = '{1'b0, 16'h0007, 1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0011, 64'h0000_0000_0005_0006, 4'd2, 4'd0};
    vecs[9]  = '{1'b0, 16'h0007, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0111, 64'h0000_0005_0006_0007, 4'd2, 4'd0};
    // flush stages 0,1 while offering input: input dropped
    vecs[10] = '{1'b0, 16'h0008, 1'b1, 4'b0000, 4'b0011, 1'b1, 4'b1100, 64'h0005_0006_0000_0000, 4'd2, 4'd1};
    vecs[11] = '{1'b0, 16'h0009, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b1001, 64'h0006_0000_0000_0009, 4'd2, 4'd1};
    vecs[12] = '{1'b0, 16'h000A, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0011, 64'h0000_0000_0009_000A, 4'd2, 4'd1};
    vecs[13] = '{1'b0, 16'h000B, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0111, 64'h0000_0009_000A_000B, 4'd2, 4'd1};
    vecs[14] = '{1'b0, 16'h000C, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b1111, 64'h0009_000A_000B_000C, 4'd2, 4'd1};
    // stall and flush on the last stage together
    vecs[15] = '{1'b0, 16'h000D, 1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0111, 64'h0000_000A_000B_000C, 4'd2, 4'd2};
    // invalid entry moves like a valid one
    vecs[16] = '{1'b0, 16'h0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1110, 64'h000A_000B_000C_0000, 4'd2, 4'd2};
    vecs[17] = '{1'b0, 16'h000E, 1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0110, 64'h0000_000B_000C_0000, 4'd3, 4'd2};
    // reset during a stall and flush: in_ready still follows the stall
    vecs[18] = '{1'b1, 16'h000F, 1'b1, 4'b0010, 4'b0001, 1'b0, 4'b0000, 64'h0000_0000_0000_0000, 4'd0, 4'd0};
    vecs[19] = '{1'b0, 16'h0007, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0001, 64'h0000_0000_0000_0007, 4'd0, 4'd0};
    vecs[20] = '{1'b0, 16'h0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0010, 64'h0000_0000_0007_0000, 4'd0, 4'd0};
    vecs[21] = '{1'b0, 16'h0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0100, 64'h0000_0007_0000_0000, 4'd0, 4'd0};
    vecs[22] = '{1'b0, 16'h0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1000, 64'h0007_0000_0000_0000, 4'd0, 4'd0};

    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].din, vecs[i].vin, vecs[i].stl, vecs[i].fls);
      #1;
      chk("in_ready", i, {63'd0, in_ready}, {63'd0, vecs[i].exp_ready});
      @(posedge clk);
      #1;
      chk("stage_valid", i, {60'd0, stage_valid}, {60'd0, vecs[i].exp_sv});
      chk("stage_data", i, stage_data, vecs[i].exp_sd);
      chk("out_data", i, {48'd0, out_data}, {48'd0, vecs[i].exp_sd[63:48]});
      chk("out_valid", i, {63'd0, out_valid}, {63'd0, vecs[i].exp_sv[3]});
      chk("bubble_count", i, {60'd0, bubble_count}, {60'd0, vecs[i].exp_bc});
      chk("flush_count", i, {60'd0, flush_count}, {60'd0, vecs[i].exp_fc});
    end

    // Bubble below stage 0 and flush of stage 0 every cycle: both counters
    // climb by one per cycle and stick at 15.
    for (int i = 0; i < 20; i++) begin
      logic [3:0] exp_cnt;
      exp_cnt = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      drive(1'b0, 16'h1234, 1'b1, 4'b0001, 4'b0001);
      #1;
      chk("sat_in_ready", 100 + i, {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
      chk("sat_bubble_count", 100 + i, {60'd0, bubble_count}, {60'd0, exp_cnt});
      chk("sat_flush_count", 100 + i, {60'd0, flush_count}, {60'd0, exp_cnt});
      chk("sat_stage0_valid", 100 + i, {63'd0, stage_valid[0]}, 64'd0);
    end

    // Release and reset: counters clear, pipe empty.
    drive(1'b1, 16'h0, 1'b0, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    chk("post_reset_bubble", 200, {60'd0, bubble_count}, 64'd0);
    chk("post_reset_valid", 200, {60'd0, stage_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
